// File: rtl/prng_share_ctrl.sv
// rtl/prng_share_ctrl.sv - Fibonacci LFSR shared among N requesters with round-robin grants
module prng_share_ctrl #(
   parameter int W      = 8,
   parameter int TAPS   = 'h1D,
   parameter int N      = 4,
   parameter int SEED   = 1,
   parameter int WARMUP = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_seed_load,
   input  logic [W-1:0] i_seed_val,
   input  logic [N-1:0] i_req,
   output logic [N-1:0] o_gnt,
   output logic [W-1:0] o_rnd,
   output logic         o_rnd_valid,
   output logic         o_busy,
   output logic         o_seed_err
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam logic [W-1:0] L_TAPS = TAPS[W-1:0];
   localparam logic [W-1:0] L_SEED = SEED[W-1:0];
   localparam logic [7:0]   L_WARM = WARMUP[7:0];

   typedef enum logic {ST_WARM, ST_SERVE} state_t;
   localparam state_t L_START = (L_WARM == 8'd0) ? ST_SERVE : ST_WARM;

   state_t         r_state;
   logic [7:0]     r_wcnt;
   logic [W-1:0]   r_lfsr;
   logic [PW-1:0]  r_ptr;
   logic [N-1:0]   r_gnt;
   logic [W-1:0]   r_rnd;
   logic           r_valid;
   logic           r_err;

   state_t         w_state;
   logic [7:0]     w_wcnt;
   logic [W-1:0]   w_lfsr;
   logic [PW-1:0]  w_ptr;
   logic [N-1:0]   w_gnt;
   logic [W-1:0]   w_rnd;
   logic           w_valid;
   logic           w_err;

   logic           w_found;
   logic [PW-1:0]  w_win;
   logic [W-1:0]   w_step;

   assign w_step = {^(r_lfsr & L_TAPS), r_lfsr[W-1:1]};

   // Round-robin search: first set request at or after r_ptr, wrapping mod N.
   always_comb begin
      int idx;
      w_found = 1'b0;
      w_win   = '0;
      idx     = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(r_ptr) + i) % N;
         if (!w_found && i_req[idx[PW-1:0]]) begin
            w_found = 1'b1;
            w_win   = idx[PW-1:0];
         end
      end
   end

   always_comb begin
      int nxt;
      w_state = r_state;
      w_wcnt  = r_wcnt;
      w_lfsr  = r_lfsr;
      w_ptr   = r_ptr;
      w_gnt   = '0;
      w_rnd   = r_rnd;
      w_valid = 1'b0;
      w_err   = r_err;
      nxt     = (int'(w_win) + 1) % N;
      if (i_seed_load) begin
         w_wcnt  = L_WARM;
         w_state = L_START;
         if (i_seed_val == '0) begin
            w_lfsr = L_SEED;
            w_err  = 1'b1;
         end else begin
            w_lfsr = i_seed_val;
         end
      end else if (r_lfsr == '0) begin
         // Zero lockup: the LFSR would never leave 0, so force the fallback seed.
         w_lfsr = L_SEED;
         w_err  = 1'b1;
      end else begin
         case (r_state)
            ST_WARM: begin
               w_lfsr = w_step;
               w_wcnt = r_wcnt - 8'd1;
               if (r_wcnt <= 8'd1) begin
                  w_state = ST_SERVE;
               end
            end
            default: begin
               if (w_found) begin
                  w_gnt   = {{(N-1){1'b0}}, 1'b1} << w_win;
                  w_rnd   = r_lfsr;
                  w_valid = 1'b1;
                  w_lfsr  = w_step;
                  w_ptr   = nxt[PW-1:0];
               end
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= L_START;
         r_wcnt  <= L_WARM;
         r_lfsr  <= L_SEED;
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_rnd   <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state;
         r_wcnt  <= w_wcnt;
         r_lfsr  <= w_lfsr;
         r_ptr   <= w_ptr;
         r_gnt   <= w_gnt;
         r_rnd   <= w_rnd;
         r_valid <= w_valid;
         r_err   <= w_err;
      end
   end

   assign o_gnt       = r_gnt;
   assign o_rnd       = r_rnd;
   assign o_rnd_valid = r_valid;
   assign o_busy      = (r_state == ST_WARM);
   assign o_seed_err  = r_err;

endmodule

// File: tb/tb_prng_share_ctrl.sv
// tb/tb_prng_share_ctrl.sv - directed vectors for prng_share_ctrl (W=3, TAPS=011, N=4)
module tb_prng_share_ctrl;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_rst, a_sl, a_vld, a_busy, a_err;
   logic [2:0] a_sv, a_rnd;
   logic [3:0] a_req, a_gnt;
   logic       b_rst, b_sl, b_vld, b_busy, b_err;
   logic [2:0] b_sv, b_rnd;
   logic [3:0] b_req, b_gnt;

   int errors = 0;
   int checks = 0;

   prng_share_ctrl #(.W(3), .TAPS(3), .N(4), .SEED(1), .WARMUP(2)) u_dut_a (
      .i_clk(clk), .i_rst(a_rst), .i_seed_load(a_sl), .i_seed_val(a_sv), .i_req(a_req),
      .o_gnt(a_gnt), .o_rnd(a_rnd), .o_rnd_valid(a_vld), .o_busy(a_busy), .o_seed_err(a_err)
   );

   prng_share_ctrl #(.W(3), .TAPS(3), .N(4), .SEED(1), .WARMUP(0)) u_dut_b (
      .i_clk(clk), .i_rst(b_rst), .i_seed_load(b_sl), .i_seed_val(b_sv), .i_req(b_req),
      .o_gnt(b_gnt), .o_rnd(b_rnd), .o_rnd_valid(b_vld), .o_busy(b_busy), .o_seed_err(b_err)
   );

   typedef struct {
      logic [3:0] req;
      logic       sl;
      logic [2:0] sv;
      logic [3:0] gnt;
      logic [2:0] rnd;
      logic       vld;
      logic       busy;
      logic       err;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic [3:0] g, input logic [2:0] r,
                        input logic v, input logic bz, input logic e);
      chk({tag, ".gnt"}, 32'(a_gnt), 32'(g));
      chk({tag, ".rnd"}, 32'(a_rnd), 32'(r));
      chk({tag, ".vld"}, 32'(a_vld), 32'(v));
      chk({tag, ".busy"}, 32'(a_busy), 32'(bz));
      chk({tag, ".err"}, 32'(a_err), 32'(e));
   endtask

   initial begin
      tbl[0]  = '{4'b1111, 1'b0, 3'b000, 4'b0001, 3'b001, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{4'b1111, 1'b0, 3'b000, 4'b0010, 3'b100, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{4'b1111, 1'b0, 3'b000, 4'b0100, 3'b010, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{4'b1111, 1'b0, 3'b000, 4'b1000, 3'b101, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{4'b1111, 1'b0, 3'b000, 4'b0001, 3'b110, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{4'b0010, 1'b0, 3'b000, 4'b0010, 3'b111, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{4'b0011, 1'b0, 3'b000, 4'b0001, 3'b011, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{4'b0011, 1'b0, 3'b000, 4'b0010, 3'b001, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{4'b1000, 1'b0, 3'b000, 4'b1000, 3'b100, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{4'b0000, 1'b0, 3'b000, 4'b0000, 3'b100, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{4'b0000, 1'b0, 3'b000, 4'b0000, 3'b100, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{4'b0001, 1'b0, 3'b000, 4'b0001, 3'b010, 1'b1, 1'b0, 1'b0};
      tbl[12] = '{4'b1111, 1'b1, 3'b000, 4'b0000, 3'b010, 1'b0, 1'b0, 1'b1};
      tbl[13] = '{4'b1111, 1'b0, 3'b000, 4'b0010, 3'b001, 1'b1, 1'b0, 1'b1};
      tbl[14] = '{4'b0100, 1'b1, 3'b110, 4'b0000, 3'b001, 1'b0, 1'b0, 1'b1};
      tbl[15] = '{4'b0100, 1'b0, 3'b000, 4'b0100, 3'b110, 1'b1, 1'b0, 1'b1};

      a_rst = 1'b1; a_sl = 1'b0; a_sv = 3'b000; a_req = 4'b0000;
      b_rst = 1'b1; b_sl = 1'b0; b_sv = 3'b000; b_req = 4'b0000;
      #1;
      chk_a("a_reset", 4'b0000, 3'b000, 1'b0, 1'b1, 1'b0);
      chk("b_reset.busy", 32'(b_busy), 32'd0);
      chk("b_reset.vld", 32'(b_vld), 32'd0);
      tick();
      a_rst = 1'b0;
      b_rst = 1'b0;

      // Warm-up of two steps, then a single requester drains consecutive words.
      a_req = 4'b0001;
      tick(); chk_a("warm1", 4'b0000, 3'b000, 1'b0, 1'b1, 1'b0);
      tick(); chk_a("warm2", 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0);
      tick(); chk_a("w1", 4'b0001, 3'b010, 1'b1, 1'b0, 1'b0);
      tick(); chk_a("w2", 4'b0001, 3'b101, 1'b1, 1'b0, 1'b0);
      tick(); chk_a("w3", 4'b0001, 3'b110, 1'b1, 1'b0, 1'b0);

      // Zero seed in SERVE: no grant, sticky error, restart from fallback seed.
      a_req = 4'b1111; a_sl = 1'b1; a_sv = 3'b000;
      tick(); chk_a("zseed", 4'b0000, 3'b110, 1'b0, 1'b1, 1'b1);
      a_sl = 1'b0;
      tick(); chk_a("zwarm1", 4'b0000, 3'b110, 1'b0, 1'b1, 1'b1);
      tick(); chk_a("zwarm2", 4'b0000, 3'b110, 1'b0, 1'b0, 1'b1);
      tick(); chk_a("zgnt", 4'b0010, 3'b010, 1'b1, 1'b0, 1'b1);

      // Seed load against pending requests: seed wins, first word is 110 stepped twice.
      a_sl = 1'b1; a_sv = 3'b110;
      tick(); chk_a("sload", 4'b0000, 3'b010, 1'b0, 1'b1, 1'b1);
      a_sl = 1'b0;
      tick(); chk_a("swarm1", 4'b0000, 3'b010, 1'b0, 1'b1, 1'b1);
      tick(); chk_a("swarm2", 4'b0000, 3'b010, 1'b0, 1'b0, 1'b1);
      tick(); chk_a("sgnt1", 4'b0100, 3'b011, 1'b1, 1'b0, 1'b1);
      tick(); chk_a("sgnt2", 4'b1000, 3'b001, 1'b1, 1'b0, 1'b1);

      // Asynchronous reset between edges while a grant is showing.
      #2 a_rst = 1'b1;
      #1 chk_a("arst", 4'b0000, 3'b000, 1'b0, 1'b1, 1'b0);
      #1 a_rst = 1'b0;
      tick(); chk_a("rwarm1", 4'b0000, 3'b000, 1'b0, 1'b1, 1'b0);
      tick(); chk_a("rwarm2", 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0);
      tick(); chk_a("rgnt", 4'b0001, 3'b010, 1'b1, 1'b0, 1'b0);
      a_req = 4'b0000;

      for (int i = 0; i < 16; i++) begin
         b_req = tbl[i].req;
         b_sl  = tbl[i].sl;
         b_sv  = tbl[i].sv;
         tick();
         chk($sformatf("row%0d.gnt", i), 32'(b_gnt), 32'(tbl[i].gnt));
         chk($sformatf("row%0d.rnd", i), 32'(b_rnd), 32'(tbl[i].rnd));
         chk($sformatf("row%0d.vld", i), 32'(b_vld), 32'(tbl[i].vld));
         chk($sformatf("row%0d.busy", i), 32'(b_busy), 32'(tbl[i].busy));
         chk($sformatf("row%0d.err", i), 32'(b_err), 32'(tbl[i].err));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
